// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter with burst lock sharing one synchronous-FIFO write port.
// Per-requester data gating lives in a lane cell; the lanes are OR-merged onto fifo_data_in.

module fifo_wr_arbiter_lane #(
    parameter int WIDTH = 3
) (
    input  logic             gnt,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] data_q
);
    assign data_q = gnt ? data : '0;
endmodule

module fifo_wr_arbiter #(
    parameter int WIDTH     = 3,
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         gnt,
    input  logic                       fifo_full,
    output logic                       fifo_write_en,
    output logic [WIDTH-1:0]           fifo_data_in,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner_id
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BURST_LEN + 1);

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_BURST = 1'b1;

    logic                            state;
    logic [IW-1:0]                   ptr, owner, win, grant_idx;
    logic [CW-1:0]                   beat_cnt;
    logic                            found, grant_en;
    logic [NUM_REQ-1:0][WIDTH-1:0]   lane_data;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (i == IW'(NUM_REQ - 1)) return '0;
        else                       return i + IW'(1);
    endfunction

    // First active requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[IW'(idx)]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    assign grant_idx = (state == STATE_BURST) ? owner : win;
    assign grant_en  = rst_n && !fifo_full &&
                       ((state == STATE_BURST) ? req[owner] : found);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign gnt[gi] = grant_en && (grant_idx == IW'(gi));
            fifo_wr_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
                .gnt    (gnt[gi]),
                .data   (req_data[gi*WIDTH +: WIDTH]),
                .data_q (lane_data[gi])
            );
        end
    endgenerate

    always_comb begin
        fifo_data_in = '0;
        for (int k = 0; k < NUM_REQ; k++) fifo_data_in = fifo_data_in | lane_data[k];
    end

    assign fifo_write_en = |gnt;
    assign busy          = (state == STATE_BURST);
    assign owner_id      = owner;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= STATE_IDLE;
            ptr      <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (found && !fifo_full) begin
                        owner <= win;
                        if (BURST_LEN == 1) begin
                            ptr <= next_idx(win);
                        end else begin
                            beat_cnt <= CW'(1);
                            state    <= STATE_BURST;
                        end
                    end
                end
                default: begin
                    // Owner dropping req ends the tenure; a full stall just freezes it.
                    if (!req[owner]) begin
                        state <= STATE_IDLE;
                        ptr   <= next_idx(owner);
                    end else if (!fifo_full) begin
                        beat_cnt <= beat_cnt + CW'(1);
                        if (beat_cnt + CW'(1) == CW'(BURST_LEN)) begin
                            state <= STATE_IDLE;
                            ptr   <= next_idx(owner);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: one instance with BURST_LEN=1, one with BURST_LEN=3, shared stimulus,
// plus a small queue standing in for the 4-deep FIFO in the integration step.

module tb_fifo_wr_arbiter;
    logic        clk, rst_n, fifo_full;
    logic [3:0]  req;
    logic [11:0] req_data;

    logic [3:0]  gnt1, gnt3;
    logic        we1, we3, busy1, busy3;
    logic [2:0]  data1, data3;
    logic [1:0]  own1, own3;

    int total = 0;
    int bad   = 0;
    int q[$];

    fifo_wr_arbiter #(.WIDTH(3), .NUM_REQ(4), .BURST_LEN(1)) u_bl1 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt1),
        .fifo_full(fifo_full), .fifo_write_en(we1), .fifo_data_in(data1),
        .busy(busy1), .owner_id(own1)
    );

    fifo_wr_arbiter #(.WIDTH(3), .NUM_REQ(4), .BURST_LEN(3)) u_bl3 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt3),
        .fifo_full(fifo_full), .fifo_write_en(we3), .fifo_data_in(data3),
        .busy(busy3), .owner_id(own3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] g2 [5];
        logic [2:0] d2 [5];
        logic [3:0] g3 [9];
        logic       b3 [9];
        logic [2:0] d3 [9];
        logic       f4 [6];
        logic [3:0] g4 [6];
        logic       b4 [6];
        int         v;

        g2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        d2 = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
        g3 = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100,
               4'b0001, 4'b0001, 4'b0001};
        b3 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        d3 = '{3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3, 3'd1, 3'd1, 3'd1};
        f4 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        g4 = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0010};
        b4 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_n     = 1'b0;
        fifo_full = 1'b0;
        req       = 4'b1111;
        req_data  = {3'd4, 3'd3, 3'd2, 3'd1};

        // Reset held for three cycles with every requester active.
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("rst_gnt1", gnt1, 4'b0000);
            chk("rst_gnt3", gnt3, 4'b0000);
            chk("rst_we1", we1, 1'b0);
            chk("rst_data1", data1, 3'd0);
            tick();
            chk("rst_busy3", busy3, 1'b0);
            chk("rst_owner3", own3, 2'd0);
        end

        // Single-beat round robin.
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("rr_gnt", gnt1, g2[c]);
            chk("rr_data", data1, d2[c]);
            chk("rr_busy", busy1, 1'b0);
            tick();
        end

        // Bursts of three alternating between req0 and req2.
        req = 4'b0101;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            #1;
            chk("burst_gnt", gnt3, g3[c]);
            chk("burst_busy", busy3, b3[c]);
            chk("burst_data", data3, d3[c]);
            tick();
        end

        // Full stall in the middle of req0's burst.
        req = 4'b0011;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            fifo_full = f4[c];
            #1;
            chk("stall_gnt", gnt3, g4[c]);
            chk("stall_busy", busy3, b4[c]);
            chk("stall_we", we3, (g4[c] != 4'b0000));
            tick();
        end
        fifo_full = 1'b0;

        // Reset lands while req1 owns a burst: burst aborted, arbitration back at 0.
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", gnt3, 4'b0000);
        tick();
        rst_n = 1'b1;
        chk("midrst_busy", busy3, 1'b0);
        chk("midrst_owner", own3, 2'd0);
        #1;
        chk("midrst_restart", gnt3, 4'b0001);
        tick();

        // Early release after one beat costs a bubble.
        req = 4'b0101;
        do_reset();
        #1;
        chk("rel_gnt_c1", gnt3, 4'b0001);
        tick();
        req = 4'b0100;
        #1;
        chk("rel_gnt_c2", gnt3, 4'b0000);
        chk("rel_busy_c2", busy3, 1'b1);
        tick();
        #1;
        chk("rel_gnt_c3", gnt3, 4'b0100);
        chk("rel_busy_c3", busy3, 1'b0);
        chk("rel_owner_c3", own3, 2'd0);
        tick();

        // Integration with a 4-deep FIFO, no reads until it fills.
        req = 4'b1111;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            fifo_full = (q.size() == 4);
            #1;
            if (c < 4) begin
                chk("int_fill_gnt", gnt1, g2[c]);
                chk("int_fill_data", data1, d2[c]);
            end else begin
                chk("int_full_gnt", gnt1, 4'b0000);
                chk("int_full_we", we1, 1'b0);
            end
            if (we1) q.push_back(int'(data1));
            tick();
        end
        chk("int_depth", q.size(), 4);

        // Reads drain one word per cycle; writes resume from req0 once space opens.
        for (int c = 0; c < 4; c++) begin
            fifo_full = (q.size() == 4);
            #1;
            if (c == 0) chk("int_rd_gnt", gnt1, 4'b0000);
            else        chk("int_rd_gnt", gnt1, g2[c-1]);
            v = q.pop_front();
            chk("int_rd_val", v, c + 1);
            if (we1) q.push_back(int'(data1));
            tick();
        end
        fifo_full = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
